// File: rtl/vga_pixel_serializer.sv
// Pixel serializer that sits after VGA_data_controller.
// Incoming pixel words are buffered in a small FIFO. Requests for more words
// are issued ahead of need. During the active region the words are shifted
// out one 1-bpp pixel per clock, MSB first. Sticky flags report FIFO
// underflow and overflow.
module vga_pixel_serializer #(
  parameter int WORD_W        = 32,
  parameter int ACTIVE_PIXELS = 640,
  parameter int DEPTH         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        VGA_state,
  input  logic [WORD_W-1:0] data_to_VGA,
  input  logic              data_en,
  input  logic              clear_flags,
  output logic              word_req,
  output logic              pixel_out,
  output logic              pixel_valid,
  output logic              underflow,
  output logic              overflow
);

  localparam int WORDS_PER_LINE = ACTIVE_PIXELS / WORD_W;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WORD_W);
  localparam int LW = $clog2(WORDS_PER_LINE + 1);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {
    ST_SYNC       = 2'd0,
    ST_BACKPORCH  = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_FRONTPORCH = 2'd3
  } vga_state_e;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic [WORD_W-1:0] shreg;
  logic              loaded;
  logic [IW-1:0]     pix_idx;

  logic [AW:0]       outstanding;
  logic [AW:0]       out_next;
  logic [LW-1:0]     line_words;
  logic [1:0]        prev_state;

  logic              in_active;
  logic              line_start;
  logic              pop;
  logic              wr_ok;
  logic              req_next;
  logic              last_pixel;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;
  assign in_active  = (VGA_state == ST_ACTIVE);
  assign line_start = (prev_state != ST_SYNC) && (VGA_state == ST_SYNC);
  assign last_pixel = (pix_idx == IW'(WORD_W - 1));

  // Decide this cycle's pop, write acceptance and next request.
  // A pop frees a slot in the same cycle, so a write landing on a full FIFO
  // that is also being popped (or flushed) still succeeds.
  always_comb begin
    pop      = 1'b0;
    wr_ok    = 1'b0;
    req_next = 1'b0;
    if (!line_start && !fifo_empty) begin
      pop = in_active ? last_pixel : !loaded;
    end
    wr_ok    = data_en && (!fifo_full || pop || line_start);
    req_next = ((CW'(fifo_count) + CW'(outstanding)) < CW'(DEPTH)) &&
               (line_words < LW'(WORDS_PER_LINE)) && !word_req;
  end

  // Track requests that upstream has not answered yet; never go below zero.
  always_comb begin
    out_next = outstanding;
    if (word_req && !data_en) begin
      out_next = outstanding + (AW+1)'(1);
    end else if (!word_req && data_en && (outstanding != '0)) begin
      out_next = outstanding - (AW+1)'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_to_VGA;
    end
  end

  // FIFO pointers; a line start discards everything buffered so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (line_start) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
    end
  end

  // Request generator, in-flight count and per-line request budget.
  // At a line start, words still in flight are credited to the new line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_req    <= 1'b0;
      outstanding <= '0;
      line_words  <= '0;
      prev_state  <= ST_SYNC;
    end else begin
      word_req    <= req_next;
      outstanding <= out_next;
      prev_state  <= VGA_state;
      if (line_start) begin
        line_words <= LW'(out_next);
      end else if (word_req) begin
        line_words <= line_words + LW'(1);
      end
    end
  end

  // Shifter: preload between lines, shift one pixel per active cycle.
  // pix_idx keeps counting while empty so pixels stay aligned to words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      loaded      <= 1'b0;
      pix_idx     <= '0;
      pixel_out   <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= in_active;
      pixel_out   <= 1'b0;
      if (line_start) begin
        loaded  <= 1'b0;
        pix_idx <= '0;
      end else if (in_active) begin
        pixel_out <= loaded & shreg[WORD_W-1];
        pix_idx   <= pix_idx + IW'(1);
        if (last_pixel) begin
          loaded <= pop;
          if (pop) begin
            shreg <= mem[rd_ptr[AW-1:0]];
          end
        end else begin
          shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
      end else if (pop) begin
        shreg  <= mem[rd_ptr[AW-1:0]];
        loaded <= 1'b1;
      end
    end
  end

  // Sticky debug flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (in_active && !loaded) || (underflow && !clear_flags);
      overflow  <= (data_en && !wr_ok) || (overflow && !clear_flags);
    end
  end

endmodule

// File: tb/tb_vga_pixel_serializer.sv
// Self-checking bench for vga_pixel_serializer: a queue-based reference model
// checked every cycle, plus directed line scenarios with literal expectations.
module tb_vga_pixel_serializer;

  localparam int DEPTH = 4;
  localparam int WPL   = 20;

  logic        tb_clk      = 1'b0;
  logic        rst         = 1'b0;
  logic [1:0]  vga_state   = 2'd0;
  logic [31:0] data_word   = '0;
  logic        data_en     = 1'b0;
  logic        clear_flags = 1'b0;
  logic        word_req;
  logic        pixel_out;
  logic        pixel_valid;
  logic        underflow;
  logic        overflow;

  vga_pixel_serializer #(.WORD_W(32), .ACTIVE_PIXELS(640), .DEPTH(DEPTH)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .VGA_state  (vga_state),
    .data_to_VGA(data_word),
    .data_en    (data_en),
    .clear_flags(clear_flags),
    .word_req   (word_req),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .underflow  (underflow),
    .overflow   (overflow)
  );

  // 25 MHz pixel clock
  always #20 tb_clk = ~tb_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model state
  logic [31:0] m_fifo [$];
  logic [31:0] m_word;
  bit          m_loaded;
  int          m_idx, m_out, m_lines;
  bit          m_req, m_pix, m_valid, m_uf, m_of;
  logic [1:0]  m_prev;

  function automatic void model_reset();
    m_fifo.delete();
    m_word = '0; m_loaded = 0; m_idx = 0; m_out = 0; m_lines = 0;
    m_req = 0; m_pix = 0; m_valid = 0; m_uf = 0; m_of = 0; m_prev = 2'd0;
  endfunction

  function automatic void model_step();
    bit boundary, active, do_pop, accept, new_req;
    int n_out;
    logic [31:0] head;
    boundary = (m_prev != 2'd0) && (vga_state == 2'd0);
    active   = (vga_state == 2'd2);
    do_pop   = !boundary && (m_fifo.size() > 0) && (active ? (m_idx == 31) : !m_loaded);
    accept   = data_en && ((m_fifo.size() < DEPTH) || do_pop || boundary);
    new_req  = ((m_fifo.size() + m_out) < DEPTH) && (m_lines < WPL) && !m_req;
    n_out    = m_out + int'(m_req) - int'(data_en);
    if (n_out < 0) n_out = 0;
    head     = do_pop ? m_fifo[0] : '0;
    m_pix    = active && m_loaded && m_word[31 - m_idx];
    m_valid  = active;
    m_uf     = (m_uf && !clear_flags) || (active && !m_loaded);
    m_of     = (m_of && !clear_flags) || (data_en && !accept);
    if (boundary) begin
      m_loaded = 0;
      m_idx    = 0;
    end else if (active) begin
      if (m_idx == 31) begin
        m_loaded = do_pop;
        if (do_pop) m_word = head;
      end
      m_idx = (m_idx + 1) % 32;
    end else if (do_pop) begin
      m_word   = head;
      m_loaded = 1;
    end
    if (boundary) m_fifo.delete();
    else if (do_pop) void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back(data_word);
    m_lines = boundary ? n_out : m_lines + int'(m_req);
    m_out   = n_out;
    m_req   = new_req;
    m_prev  = vga_state;
  endfunction

  // Advance the model at every edge and compare all outputs just after it.
  always @(posedge tb_clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    check_output("pixel_out",   int'(pixel_out),   int'(m_pix));
    check_output("pixel_valid", int'(pixel_valid), int'(m_valid));
    check_output("word_req",    int'(word_req),    int'(m_req));
    check_output("underflow",   int'(underflow),   int'(m_uf));
    check_output("overflow",    int'(overflow),    int'(m_of));
  end

  // Upstream emulation and stimulus bookkeeping
  logic [31:0] pattern [4] = '{32'h00000000, 32'hFFFFFFFF, 32'h6AAA5556, 32'h2468ACE1};
  int  cyc = 0;
  int  due_q [$];
  int  last_due = -1;
  bit  resp_on, pat_mode, rand_mode, record_on, inj_once, clr_once, last_req;
  int  lat_min = 2, lat_max = 2;
  int  word_idx, req_count, b2b;
  bit  px_q [$];

  function automatic logic [31:0] next_word();
    logic [31:0] w;
    if (pat_mode) begin
      w = pattern[word_idx % 4];
      word_idx++;
    end else begin
      w = $urandom;
    end
    return w;
  endfunction

  task automatic apply_stimulus(input logic [1:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge tb_clk);
      if (word_req) begin
        req_count++;
        if (last_req) b2b++;
        if (resp_on) begin
          int due;
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          due_q.push_back(due);
          last_due = due;
        end
      end
      last_req = word_req;
      if (record_on && pixel_valid) px_q.push_back(pixel_out);
      vga_state   = st;
      data_en     = 1'b0;
      clear_flags = 1'b0;
      data_word   = $urandom;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        data_en   = 1'b1;
        data_word = next_word();
      end else if (inj_once) begin
        inj_once  = 0;
        data_en   = 1'b1;
        data_word = 32'hDEADBEEF;
      end else if (rand_mode && $urandom_range(99, 0) == 0) begin
        data_en = 1'b1;
      end
      if (clr_once) begin
        clr_once    = 0;
        clear_flags = 1'b1;
      end else if (rand_mode) begin
        clear_flags = ($urandom_range(49, 0) == 0);
      end
      cyc++;
    end
  endtask

  task automatic do_reset(input logic [1:0] st);
    @(negedge tb_clk);
    rst = 1'b1; data_en = 1'b0; clear_flags = 1'b0; vga_state = 2'd0;
    due_q.delete(); last_due = -1; word_idx = 0; last_req = 0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
    vga_state = st;
    cyc++;
  endtask

  task automatic run_line(input int active_len);
    apply_stimulus(2'd0, 96);
    apply_stimulus(2'd1, 48);
    apply_stimulus(2'd2, active_len);
    apply_stimulus(2'd3, 16);
  endtask

  task automatic check_stream(input string name, input int nwords);
    int errs;
    logic [31:0] w;
    errs = 0;
    check_output({name, "_len"}, px_q.size(), nwords * 32);
    for (int k = 0; k < px_q.size() && k < nwords * 32; k++) begin
      w = pattern[(k / 32) % 4];
      if (px_q[k] !== w[31 - (k % 32)]) errs++;
    end
    check_output({name, "_bits"}, errs, 0);
  endtask

  initial begin
    logic [7:0] head8;
    int ones;
    #5 rst = 1'b1;
    $display("[TB] start");

    // Full line with the fixed word pattern
    do_reset(2'd0);
    resp_on = 1; pat_mode = 1; lat_min = 2; lat_max = 2;
    req_count = 0; px_q.delete(); record_on = 1;
    apply_stimulus(2'd0, 95);
    apply_stimulus(2'd1, 48);
    apply_stimulus(2'd2, 640);
    apply_stimulus(2'd3, 16);
    record_on = 0;
    check_output("full_line_reqs", req_count, WPL);
    check_stream("full_line", WPL);
    head8 = '0;
    for (int i = 0; i < 8; i++) head8[7-i] = (px_q.size() > 64 + i) ? px_q[64+i] : 1'b0;
    check_output("word3_head", int'(head8), 32'h6A);
    check_output("full_line_underflow", int'(underflow), 0);
    check_output("full_line_overflow", int'(overflow), 0);

    // Short line leaves words buffered; the next line must start fresh
    run_line(64);
    check_output("no_pending_at_boundary", due_q.size(), 0);
    word_idx = 0; req_count = 0; px_q.delete(); record_on = 1;
    run_line(640);
    record_on = 0;
    check_output("boundary_reqs", req_count, WPL);
    check_stream("boundary", WPL);

    // Mid-line reset forces outputs low without waiting for a clock edge
    apply_stimulus(2'd0, 96);
    apply_stimulus(2'd1, 48);
    apply_stimulus(2'd2, 100);
    @(negedge tb_clk);
    rst = 1'b1;
    #1;
    check_output("rst_pixel_out",   int'(pixel_out),   0);
    check_output("rst_pixel_valid", int'(pixel_valid), 0);
    check_output("rst_word_req",    int'(word_req),    0);
    check_output("rst_underflow",   int'(underflow),   0);
    check_output("rst_overflow",    int'(overflow),    0);
    due_q.delete(); last_due = -1; last_req = 0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0; vga_state = 2'd0; data_en = 1'b0; cyc++;
    resp_on = 0; req_count = 0; b2b = 0;
    apply_stimulus(2'd0, 12);
    check_output("post_reset_reqs", req_count, DEPTH);
    check_output("post_reset_alternate", b2b, 0);

    // Underflow: upstream never answers
    do_reset(2'd0);
    resp_on = 0;
    apply_stimulus(2'd0, 9);
    apply_stimulus(2'd1, 10);
    px_q.delete(); record_on = 1;
    apply_stimulus(2'd2, 2);
    check_output("underflow_set", int'(underflow), 1);
    apply_stimulus(2'd2, 62);
    apply_stimulus(2'd3, 2);
    record_on = 0;
    ones = 0;
    foreach (px_q[k]) ones += int'(px_q[k]);
    check_output("underflow_pixels_len", px_q.size(), 64);
    check_output("underflow_pixels_zero", ones, 0);
    clr_once = 1;
    apply_stimulus(2'd3, 3);
    check_output("underflow_cleared", int'(underflow), 0);

    // Overflow: fill FIFO and shifter, then push an unsolicited word
    do_reset(2'd0);
    resp_on = 1; pat_mode = 1; lat_min = 2; lat_max = 2; req_count = 0;
    apply_stimulus(2'd0, 30);
    inj_once = 1;
    apply_stimulus(2'd0, 2);
    check_output("overflow_set", int'(overflow), 1);
    px_q.delete(); record_on = 1;
    apply_stimulus(2'd0, 64);
    apply_stimulus(2'd1, 48);
    apply_stimulus(2'd2, 640);
    apply_stimulus(2'd3, 16);
    record_on = 0;
    check_output("overflow_line_reqs", req_count, WPL);
    check_stream("overflow_line", WPL);

    // Late word: requested in FRONTPORCH, delivered 3 cycles into SYNC
    do_reset(2'd3);
    resp_on = 1; pat_mode = 1; lat_min = 4; lat_max = 4;
    apply_stimulus(2'd3, 1);
    req_count = 0; px_q.delete(); record_on = 1;
    run_line(640);
    record_on = 0;
    check_output("late_word_reqs", req_count, WPL - 1);
    check_stream("late_word", WPL);

    // Randomized lines with random latency, stray words and flag clears
    do_reset(2'd0);
    resp_on = 1; pat_mode = 0; rand_mode = 1;
    for (int l = 0; l < 15; l++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(8, 1));
      apply_stimulus(2'd0, int'($urandom_range(40, 2)));
      apply_stimulus(2'd1, int'($urandom_range(60, 2)));
      apply_stimulus(2'd2, int'($urandom_range(200, 30)));
      apply_stimulus(2'd3, int'($urandom_range(30, 2)));
    end
    rand_mode = 0;
    apply_stimulus(2'd0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_serializer.md
# vga_pixel_serializer

Downstream stage of `VGA_data_controller`. It accepts 32-bit pixel words on `data_to_VGA`/`data_en`, buffers them in a small word FIFO and issues one-cycle word requests ahead of need. During the active region it shifts one 1-bpp pixel per clock, MSB first, to the DAC/colour driver. It also flags underflow and overflow conditions for debug.

## Interface
- `WORD_W`, 32, pixel word width; one bit per pixel, MSB shown first.
- `ACTIVE_PIXELS`, 640, pixels per active line; must be a multiple of `WORD_W`, giving `WORDS_PER_LINE` = 20.
- `DEPTH`, 4, FIFO depth in words; must be a power of two and at least 2.
- Ports:
  - `clk`  in  1  pixel clock, 25 MHz.
  - `rst`  in  1  reset; asynchronous, active-high.
  - `VGA_state`  in  2  0 = SYNC, 1 = BACKPORCH, 2 = ACTIVE, 3 = FRONTPORCH.
  - `data_to_VGA`  in  WORD_W  pixel word from `VGA_data_controller`.
  - `data_en`  in  1  one-cycle strobe; `data_to_VGA` is valid this cycle.
  - `clear_flags`  in  1  synchronous clear of the sticky flags.
  - `word_req`  out  1  one-cycle request for the next pixel word.
  - `pixel_out`  out  1  registered pixel.
  - `pixel_valid`  out  1  registered copy of (`VGA_state`==2).
  - `underflow`  out  1  sticky: an active pixel was needed while the shifter was empty.
  - `overflow`  out  1  sticky: a word arrived while the FIFO was full.

## Operation

**Reset**
- All outputs 0.
- FIFO empty; shifter unloaded; `pix_idx` = 0.
- Outstanding counter 0; line word counter 0; `prev_state` = 0.

**FIFO**
- A write occurs on `data_en`.
- If the FIFO is full, the word is dropped and `overflow` is set.
- Pointers have width log2(`DEPTH`)+1; full/empty are decided from the MSB compare.

**Request generator**
- `word_req` is asserted for one cycle when all of the following hold:
  - `fifo_count + outstanding < DEPTH`
  - `line_words < WORDS_PER_LINE`
  - `word_req` was not asserted last cycle
- `outstanding` increments on `word_req` and decrements on `data_en`. If both occur in the same cycle, it is unchanged. It saturates at 0.
- `line_words` increments on each `word_req`.
- Requests are permitted in every state.

**Shifter**
- 32-bit shift register with a `loaded` flag and a 5-bit `pix_idx`.
- Outside ACTIVE: if `loaded`=0 and the FIFO is not empty, pop the FIFO head into the shifter and set `loaded`=1.
- In ACTIVE, each cycle:
  - `pixel_out` <= `shreg[31]` when `loaded`; otherwise `pixel_out` <= 0 and `underflow` is set.
  - Shift left by 1; `pix_idx` +1.
  - When `pix_idx`=31: pop the FIFO into the shifter if it is non-empty, otherwise clear `loaded`. `pix_idx` wraps to 0.
  - When `loaded`=0 in ACTIVE, `pix_idx` still advances, so the pixel-to-word alignment is preserved.
- Outside ACTIVE, `pixel_out` = 0.

**Line boundary**
- On the transition (`prev_state`!=0 and `VGA_state`==0):
  - Flush the FIFO and clear `loaded`, `pix_idx` and `line_words`.
  - `outstanding` is not cleared. Late words arriving afterwards are written normally and count toward the new line.

**Flags**
- `underflow` and `overflow` hold until `clear_flags` or `rst`.
- If `clear_flags` and a set condition occur in the same cycle, the flag is set (set wins).

## Timing
- Pixel latency: the pixel for an ACTIVE cycle at edge N appears on `pixel_out`/`pixel_valid` after edge N. The upstream timing generator compensates by delaying sync outputs by 1 cycle.
- `data_en` may arrive any number of cycles after `word_req`. Each `word_req` yields at most one `data_en`.
- Prefetch:
  - From a flushed state, `DEPTH` requests are issued on alternate cycles. Requests resume as pops free space.
  - The first word reaches the shifter in the cycle after it is written.
  - With `DEPTH`=4 and a 2-cycle upstream latency, the 48-cycle backporch fills the shifter plus 4 FIFO words.
- Steady state: one pop per 32 ACTIVE cycles, so about one `word_req` per 32 cycles. Total requests per line are exactly `WORDS_PER_LINE`.
- A simultaneous write and pop on a full FIFO is accepted; no overflow is flagged.
- `rst` asserted mid-line forces all outputs to 0 immediately (asynchronously). After release, operation resumes from the reset state at the next SYNC or ACTIVE, as applicable.

## Test plan
- **Mid-line reset:** assert `rst` during ACTIVE with a pixel stream running. Required: `pixel_out`, `pixel_valid`, `word_req`, `underflow` and `overflow` all read 0 before the next clock edge. After release in SYNC, 4 `word_req` pulses follow on alternate cycles.
- **Full line:** drive SYNC 96, BACKPORCH 48, ACTIVE 640, FRONTPORCH 16 cycles. Upstream answers each request 2 cycles later, with words cycling 0x00000000, 0xFFFFFFFF, 0x6AAA5556, 0x[national-id]. Required: the `pixel_out` stream equals the words MSB-first, e.g. word 3 starts 0,1,1,0,1,0,1,0; exactly 20 `word_req` pulses; `underflow`=0.
- **Underflow:** never assert `data_en`. Required: `pixel_out`=0 across ACTIVE; `underflow`=1 from the first ACTIVE output cycle; it holds until `clear_flags`, then reads 0.
- **Overflow:** fill the FIFO (4 words) plus the shifter, then inject an unsolicited `data_en` with 0xDEADBEEF. Required: `overflow`=1; the word is dropped, and the subsequent pixel stream contains no 0xDEADBEEF bits.
- **Line boundary:** go from FRONTPORCH to SYNC with 2 words left in the FIFO. Required: FIFO flushed; `line_words` reset; the next line issues 20 fresh requests; the first ACTIVE pixel comes from the first word of the new line.
- **Late word across boundary:** issue a request in FRONTPORCH, then deliver `data_en` 3 cycles after SYNC entry. Required: the word is written after the flush and becomes the shifter's first word; the new line issues 19 requests.
